branch_resolver: RTL

- Consumes the status_register flags produced by the execute-stage ALU and the branch target computed on alu_result.
- Evaluates the ARM condition field of conditional and unconditional branches, then issues a one-cycle PC redirect to fetch.
- Holds a pipeline flush for a fixed number of non-stalled cycles after each taken branch.
- Sits in the execute stage beside the ALU and keeps performance counters of branches seen and taken.

---
 rtl/branch_resolver_pkg.sv | 15 +
 rtl/branch_resolver_cond_eval.sv | 34 +++
 rtl/branch_resolver.sv | 66 ++++++
 3 files changed

// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: shared execute-stage types for branch resolution and conditional execution
package branch_resolver_pkg;
   localparam int WORD = 32;
   typedef enum logic [3:0] {
      CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
      CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
   } condition_code_e;
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } status_register_t;
   typedef enum logic {BR_IDLE, BR_FLUSH} branch_state_e;
endpackage

// File: rtl/branch_resolver_cond_eval.sv
// cond_eval: combinational ARM condition-field check against the current NZCV flags
module cond_eval
   import branch_resolver_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] status_reg_i,
   output logic       taken_o
);
   status_register_t f;
   condition_code_e  cc;
   assign f  = status_register_t'(status_reg_i);
   assign cc = condition_code_e'(cond_i);
   always_comb begin
      taken_o = 1'b0;
      case (cc)
         CC_EQ: taken_o = f.z;
         CC_NE: taken_o = !f.z;
         CC_CS: taken_o = f.c;
         CC_CC: taken_o = !f.c;
         CC_MI: taken_o = f.n;
         CC_PL: taken_o = !f.n;
         CC_VS: taken_o = f.v;
         CC_VC: taken_o = !f.v;
         CC_HI: taken_o = f.c && !f.z;
         CC_LS: taken_o = !f.c || f.z;
         CC_GE: taken_o = f.n == f.v;
         CC_LT: taken_o = f.n != f.v;
         CC_GT: taken_o = !f.z && (f.n == f.v);
         CC_LE: taken_o = f.z || (f.n != f.v);
         CC_AL: taken_o = 1'b1;
         default: taken_o = 1'b0;
      endcase
   end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: resolves execute-stage branches into a one-cycle PC redirect plus a fixed flush window,
// and counts branches seen and taken.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 is_valid_i,
   input  logic                 is_branch_i,
   input  logic                 stall_i,
   input  logic [3:0]           cond_i,
   input  logic [3:0]           status_reg_i,
   input  logic [WORD-1:0]      branch_target_i,
   output logic                 redirect_valid_o,
   output logic [WORD-1:0]      redirect_target_o,
   output logic                 flush_o,
   output logic [CNT_WIDTH-1:0] branch_count_o,
   output logic [CNT_WIDTH-1:0] taken_count_o
);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);
   branch_state_e state;
   logic [FW-1:0] flush_cnt;
   logic          taken;
   cond_eval u_cond_eval (
      .cond_i       (cond_i),
      .status_reg_i (status_reg_i),
      .taken_o      (taken)
   );
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state             <= BR_IDLE;
         flush_cnt         <= '0;
         redirect_valid_o  <= 1'b0;
         redirect_target_o <= '0;
         flush_o           <= 1'b0;
         branch_count_o    <= '0;
         taken_count_o     <= '0;
      end else if (!stall_i) begin
         case (state)
            BR_IDLE: if (is_valid_i && is_branch_i) begin
               branch_count_o <= branch_count_o + 1'b1;
               if (taken) begin
                  taken_count_o     <= taken_count_o + 1'b1;
                  redirect_target_o <= {branch_target_i[WORD-1:1], 1'b0};
                  redirect_valid_o  <= 1'b1;
                  flush_o           <= 1'b1;
                  flush_cnt         <= FW'(FLUSH_CYCLES);
                  state             <= BR_FLUSH;
               end
            end
            default: begin
               // wrong-path branches arriving here are deliberately ignored
               redirect_valid_o <= 1'b0;
               flush_cnt        <= flush_cnt - 1'b1;
               if (flush_cnt == FW'(1)) begin
                  flush_o <= 1'b0;
                  state   <= BR_IDLE;
               end
            end
         endcase
      end
   end
endmodule
